// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Holds the default widths, the requester encoding and the x0 index.
package regfile_wb_sched_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int RD_WIDTH   = ADDR_WIDTH;
  localparam int X0_IDX     = 0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_sched_wb_scoreboard.sv
// Busy scoreboard for destination registers with an outstanding write-back.
// Issue sets a bit, the committing register-file write clears it.
module wb_scoreboard
  import regfile_wb_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = regfile_wb_sched_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  issue_ready,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_IDX);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // The write committing this cycle bypasses the source flags but not the WAW check.
  assign rs1_busy    = busy_q[rs1] & ~(clr_en & (clr_idx == rs1));
  assign rs2_busy    = busy_q[rs2] & ~(clr_en & (clr_idx == rs2));
  assign issue_ready = ~((issue_rd != X0) & busy_q[issue_rd]);

endmodule

// File: rtl/regfile_wb_sched.sv
// Round-robin write-back arbiter between ALU and LSU driving the register
// file's single write port, plus the busy scoreboard used by decode.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_wb_sched_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_wb_sched_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wa,
  output logic [DATA_WIDTH-1:0] rf_wd
);

  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_IDX);

  // Handshake: a transfer happens on a clock edge where valid and ready are
  // both high; a requester keeps valid/rd/data stable until it sees ready.
  wb_src_e last_grant;
  logic    set_en;

  assign a_ready = a_valid & (~b_valid | (last_grant == WB_SRC_LSU));
  assign b_ready = b_valid & (~a_valid | (last_grant == WB_SRC_ALU));

  // Only a real conflict advances the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= WB_SRC_LSU;
    end else if (a_valid && b_valid) begin
      last_grant <= a_ready ? WB_SRC_ALU : WB_SRC_LSU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (a_ready) begin
      rf_we <= (a_rd != X0);
      rf_wa <= a_rd;
      rf_wd <= a_data;
    end else if (b_ready) begin
      rf_we <= (b_rd != X0);
      rf_wa <= b_rd;
      rf_wd <= b_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  assign set_en = issue_valid & issue_ready & (issue_rd != X0);

  wb_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (set_en),
    .set_idx    (issue_rd),
    .clr_en     (rf_we),
    .clr_idx    (rf_wa),
    .issue_rd   (issue_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .issue_ready(issue_ready),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected register-file writes are
// queued at issue time and a negedge monitor pops them as rf_we fires.
module tb_regfile_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2, rf_wa;
  logic [31:0] a_data, b_data, rf_wd;
  logic        issue_valid, issue_ready, rs1_busy, rs2_busy, rf_we;

  logic [36:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        track = 1'b1;

  regfile_wb_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got wa=%0d wd=0x%0h expected no write at %0t", rf_wa, rf_wd, $time);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_wa, rf_wd} !== e) begin
          n_err++;
          $display("FAIL wb_data: got wa=%0d wd=0x%0h expected wa=%0d wd=0x%0h at %0t",
                   rf_wa, rf_wd, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  // driver: one cycle of stimulus with hand-computed ready expectations
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                      input logic iv, input logic [4:0] ird,
                      input logic ea, input logic eb, input logic eir, input string tag);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    issue_valid = iv; issue_rd = ird;
    @(negedge clk);
    chk({tag, " a_ready"}, a_ready, ea);
    chk({tag, " b_ready"}, b_ready, eb);
    chk({tag, " issue_ready"}, issue_ready, eir);
    if (track) begin
      if (ea && ard != 5'd0) exp_q.push_back({ard, ad});
      if (eb && brd != 5'd0) exp_q.push_back({brd, bd});
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;
    issue_valid = 1'b0; issue_rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0;

    // 1: reset holds everything idle even with a request pending
    repeat (3) @(posedge clk);
    #1;
    chk("rst rf_we", rf_we, 1'b0);
    chk("rst rf_wa", rf_wa, 5'd0);
    chk("rst rf_wd", rf_wd, 32'h0);
    for (int i = 1; i < 32; i++) begin
      rs1 = 5'(i); issue_rd = 5'(i);
      #0.1;
      chk("rst rs1_busy", rs1_busy, 1'b0);
      chk("rst issue_ready", issue_ready, 1'b1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 5'd5, 32'h11, 0, 0, 0, 0, 0, 1, 0, 1, "t1");

    // 2: round robin A,B,A,B then lone requesters keep the stored order
    step(1, 5'd1,  32'hA1, 1, 5'd2,  32'hB2, 0, 0, 1, 0, 1, "rr1");
    step(1, 5'd3,  32'hA3, 1, 5'd2,  32'hB2, 0, 0, 0, 1, 1, "rr2");
    step(1, 5'd3,  32'hA3, 1, 5'd4,  32'hB4, 0, 0, 1, 0, 1, "rr3");
    step(1, 5'd11, 32'hAB, 1, 5'd4,  32'hB4, 0, 0, 0, 1, 1, "rr4");
    step(1, 5'd11, 32'hAB, 0, 0,     0,      0, 0, 1, 0, 1, "lone_a");
    step(1, 5'd8,  32'hA8, 1, 5'd10, 32'hBA, 0, 0, 1, 0, 1, "rr5");
    step(0, 0,     0,      1, 5'd10, 32'hBA, 0, 0, 0, 1, 1, "lone_b");
    step(1, 5'd13, 32'hAD, 1, 5'd14, 32'hBE, 0, 0, 0, 1, 1, "rr6");
    step(1, 5'd13, 32'hAD, 0, 0,     0,      0, 0, 1, 0, 1, "rr7");

    // 3: RAW/WAW tracking and bypass
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 1, "iss7");
    rs1 = 5'd7; rs2 = 5'd7; #1;
    chk("busy7 rs1", rs1_busy, 1'b1);
    chk("busy7 rs2", rs2_busy, 1'b1);
    chk("busy7 waw", issue_ready, 1'b0);
    step(0, 0, 0, 1, 5'd7, 32'h77, 0, 5'd7, 0, 1, 0, "wb7");
    chk("bypass rs1", rs1_busy, 1'b0);
    chk("bypass rs2", rs2_busy, 1'b0);
    chk("bypass waw", issue_ready, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 0, 0, "idle7");
    chk("clr7 rs1", rs1_busy, 1'b0);
    chk("clr7 waw", issue_ready, 1'b1);
    chk("hold rf_wa", rf_wa, 5'd7);
    chk("hold rf_wd", rf_wd, 32'h77);

    // 4: same-cycle set and clear of x9, set wins
    step(1, 5'd9, 32'h99, 0, 0, 0, 0, 0, 1, 0, 1, "wb9");
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 1, "iss9");
    rs1 = 5'd9; #1;
    chk("setwin rs1", rs1_busy, 1'b1);
    chk("setwin waw", issue_ready, 1'b0);

    // 5: x0 handshakes without writing and is never busy
    step(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 5'd9, 1, 0, 0, "wbx0");
    chk("x0 rf_we", rf_we, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0, 1, "issx0");
    rs1 = 5'd9; #1;
    chk("x0 keep9", rs1_busy, 1'b1);
    rs1 = 5'd0; #1;
    chk("x0 rs1", rs1_busy, 1'b0);
    chk("x0 waw", issue_ready, 1'b1);

    // 6: asynchronous reset drops an in-flight write
    track = 1'b0;
    step(1, 5'd12, 32'hC0C0, 0, 0, 0, 0, 5'd9, 1, 0, 0, "wb12");
    chk("pre_rst rf_we", rf_we, 1'b1);
    chk("pre_rst rf_wa", rf_wa, 5'd12);
    #1 rst_n = 1'b0;
    #1;
    chk("arst rf_we", rf_we, 1'b0);
    chk("arst rf_wa", rf_wa, 5'd0);
    chk("arst rf_wd", rf_wd, 32'h0);
    rs1 = 5'd9; issue_rd = 5'd9; #1;
    chk("arst busy9", rs1_busy, 1'b0);
    chk("arst waw9", issue_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    track = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "post1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "post2");
    chk("post rf_we", rf_we, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
